id_scan_ctrl: RTL
=================

# id_scan_ctrl

Stream-level controller around the character classifier: accepts a terminated byte string over a valid/ready handshake and sequences each accepted byte through a three-state letter/number/other recognizer. It counts identifiers (a letter followed by letters/digits) whose last character is a digit. It reports the count, string length and overflow with a one-cycle done pulse. It sits between the host byte source and the status registers.

## Interface
- COUNT_W, 8: width of match_count; count saturates at 2^COUNT_W-1.
- LEN_W, 16: width of len.
- MAX_LEN, 1024: maximum non-terminator bytes per string; must be at least 1 and at most 2^LEN_W-1.
- TERM, 8'h00: terminator byte.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new string; honoured only in IDLE.
- in_valid  in  1  in_char is valid.
- in_char  in  8  ASCII byte.
- in_ready  out  1  block accepts in_char this cycle.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse in DONE.
- match_count  out  COUNT_W  completed matching identifiers.
- len  out  LEN_W  accepted bytes, terminator excluded.
- overflow  out  1  string was cut at MAX_LEN.

## Operation
- Control FSM: IDLE, SCAN, DONE.
  - IDLE: in_ready=0, busy=0. On start, go to SCAN and clear match_count, len, overflow; classifier state becomes OTHER.
  - SCAN: in_ready=1, busy=1. A byte is accepted when in_valid and in_ready are both high. start is ignored.
  - DONE: done=1 and in_ready=0 for exactly one cycle, then IDLE. start is ignored.
- Classifier states: OTHER, LETTER, NUMBER.
  - From LETTER or NUMBER: digit goes to NUMBER; letter (a-z, A-Z) goes to LETTER; anything else goes to OTHER.
  - From OTHER: letter goes to LETTER; anything else, including a digit, goes to OTHER.
- Match counting:
  - Accepted byte is TERM: if classifier is NUMBER, increment match_count. Go to DONE. len is unchanged.
  - Accepted byte is not TERM: increment len and advance the classifier. If the classifier was NUMBER and the byte is not alphanumeric, increment match_count.
  - Accepted non-TERM byte makes len equal MAX_LEN: treat it as if a TERM followed it. Apply the byte's own rule first; then, if the resulting classifier state is NUMBER, increment again. Both increments land on the same edge, +2 at most. Set overflow=1 and go to DONE.
- match_count saturates and never wraps; the +2 case clamps as well.
- match_count, len and overflow hold their values through DONE and IDLE until the next start.

## Timing
- Reset: state IDLE, classifier OTHER, in_ready=0, busy=0, done=0, match_count=0, len=0, overflow=0.
- Reset during SCAN or DONE aborts the string; no done pulse is produced.
- start in IDLE at edge N: SCAN from N; in_ready=1 in the cycle after N; counters read 0.
- Each accepted byte updates len, match_count and the classifier at the accepting edge. The new values are visible the next cycle; throughput is one byte per cycle.
- TERM or MAX_LEN accepted at edge N: done=1 in the cycle after N only; in_ready drops in that same cycle. Final values are stable from that cycle.
- in_valid low in SCAN: no state change; gaps of any length are allowed.
- in_char may change freely while in_ready=0; it is not sampled.

## Structure
- Shared package holds:
  - Classifier state encodings (OTHER/LETTER/NUMBER).
  - Control FSM encodings (IDLE/SCAN/DONE).
  - is_letter and is_digit helper functions.
- Sub-module char_class: combinational. Takes the current classifier state and a byte; returns the next state and a match_end flag (was NUMBER and byte not alphanumeric). The controller owns the classifier state register.

## Test plan
- start; stream "ab12 x9" then 0x00 -> done one cycle after 0x00; match_count=2, len=7, overflow=0.
- Stream "12ab", then "a1b", then "9" as separate strings, each TERM-terminated -> match_count=0, 0, 0 respectively.
- MAX_LEN=4; stream "a1a1a1" -> only 4 bytes accepted; in_ready low after the 4th; done; match_count=1, len=4, overflow=1.
- COUNT_W=2; stream "a1 a1 a1 a1 a1" then 0x00 -> match_count holds at 3, never wraps to 0.
- Random in_valid gaps on "x9;y8" then 0x00 -> same result as gapless: match_count=2, len=5; start pulsed mid-SCAN has no effect.
- reset asserted after 3 bytes of "ab1..." -> next cycle all outputs 0, IDLE; fresh start then "q7" and 0x00 -> match_count=1.

Source files
------------

// File: rtl/id_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// id_scan_ctrl_pkg
// Shared definitions for the identifier scan controller:
//   - control FSM encodings (IDLE / SCAN / DONE)
//   - classifier state encodings (OTHER / LETTER / NUMBER)
//   - ASCII helper functions is_letter / is_digit
// No ports (package).
// ----------------------------------------------------------------------------
package id_scan_ctrl_pkg;

    // Control FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Classifier state encodings
    localparam logic [1:0] CLS_OTHER  = 2'd0;
    localparam logic [1:0] CLS_LETTER = 2'd1;
    localparam logic [1:0] CLS_NUMBER = 2'd2;

    // a-z or A-Z
    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
    endfunction

    // 0-9
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/id_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// id_scan_ctrl_if
// Byte-stream and status bundle between the host byte source and the
// identifier scan controller.
//
// Handshake: a byte is transferred on a rising clock edge where in_valid and
// in_ready are both high. in_ready is high only while the controller is in
// SCAN; in_char is not sampled when in_ready is low. start is a request that
// is only honoured while the controller is idle.
//
// Signals:
//   start        host -> ctrl  begin a new string (honoured only in IDLE)
//   in_valid     host -> ctrl  in_char carries a byte
//   in_char[7:0] host -> ctrl  ASCII byte
//   in_ready     ctrl -> host  byte is accepted this cycle when in_valid is high
//   busy         ctrl -> host  controller is scanning
//   done         ctrl -> host  one-cycle completion pulse
//   match_count  ctrl -> host  identifiers ending in a digit (saturating)
//   len          ctrl -> host  accepted bytes, terminator excluded
//   overflow     ctrl -> host  string was cut at the maximum length
//   dbg_state    ctrl -> host  control FSM state (debug)
//   dbg_cls      ctrl -> host  classifier state (debug)
// ----------------------------------------------------------------------------
interface id_scan_ctrl_if #(
    parameter int COUNT_W = 8,
    parameter int LEN_W   = 16
) ();
    logic               start;
    logic               in_valid;
    logic [7:0]         in_char;
    logic               in_ready;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] match_count;
    logic [LEN_W-1:0]   len;
    logic               overflow;
    logic [1:0]         dbg_state;
    logic [1:0]         dbg_cls;

    // Host side
    modport master (
        output start, in_valid, in_char,
        input  in_ready, busy, done, match_count, len, overflow, dbg_state, dbg_cls
    );

    // Controller side
    modport slave (
        input  start, in_valid, in_char,
        output in_ready, busy, done, match_count, len, overflow, dbg_state, dbg_cls
    );
endinterface

// File: rtl/id_scan_ctrl_char_class.sv
// ----------------------------------------------------------------------------
// id_scan_ctrl_char_class
// Combinational letter/number/other recognizer step. The owning controller
// keeps the state register; this block only computes the transition.
//
// Ports:
//   i_cls[1:0]       current classifier state
//   i_char[7:0]      byte being consumed
//   o_next_cls[1:0]  classifier state after consuming i_char
//   o_match_end      an identifier ending in a digit just completed
//                    (state was NUMBER and i_char is not alphanumeric)
// ----------------------------------------------------------------------------
module id_scan_ctrl_char_class
    import id_scan_ctrl_pkg::*;
(
    input  logic [1:0] i_cls,
    input  logic [7:0] i_char,
    output logic [1:0] o_next_cls,
    output logic       o_match_end
);

    logic w_letter;
    logic w_digit;
    logic w_in_ident;

    assign w_letter   = is_letter(i_char);
    assign w_digit    = is_digit(i_char);
    // A digit only extends an identifier that has already started with a letter
    assign w_in_ident = (i_cls == CLS_LETTER) || (i_cls == CLS_NUMBER);

    always_comb begin
        o_next_cls  = CLS_OTHER;
        o_match_end = 1'b0;
        if (w_letter) begin
            o_next_cls = CLS_LETTER;
        end else if (w_digit && w_in_ident) begin
            o_next_cls = CLS_NUMBER;
        end
        o_match_end = (i_cls == CLS_NUMBER) && !w_letter && !w_digit;
    end

endmodule

// File: rtl/id_scan_ctrl.sv
// ----------------------------------------------------------------------------
// id_scan_ctrl
// Accepts a terminated byte string over a valid/ready handshake, runs each
// byte through the character classifier and counts identifiers whose last
// character is a digit. Reports count, length and overflow with a one-cycle
// done pulse.
//
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high reset
//   bus    id_scan_ctrl_if.slave (start/in_valid/in_char in;
//          in_ready/busy/done/match_count/len/overflow/debug out)
//
// Parameters:
//   COUNT_W  width of match_count (saturating)
//   LEN_W    width of len
//   MAX_LEN  maximum non-terminator bytes per string (1 .. 2^LEN_W-1)
//   TERM     terminator byte
// ----------------------------------------------------------------------------
module id_scan_ctrl
    import id_scan_ctrl_pkg::*;
#(
    parameter int         COUNT_W = 8,
    parameter int         LEN_W   = 16,
    parameter int         MAX_LEN = 1024,
    parameter logic [7:0] TERM    = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    id_scan_ctrl_if.slave bus
);

    localparam logic [LEN_W-1:0]   MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [COUNT_W+1:0] CNT_MAX   = {2'b00, {COUNT_W{1'b1}}};

    logic [1:0]         r_state;
    logic [1:0]         r_cls;
    logic [COUNT_W-1:0] r_match_count;
    logic [LEN_W-1:0]   r_len;
    logic               r_overflow;

    logic               w_accept;
    logic               w_is_term;
    logic [1:0]         w_next_cls;
    logic               w_match_end;
    logic [LEN_W-1:0]   w_len_next;
    logic               w_hit_max;
    logic [1:0]         w_inc;
    logic [COUNT_W+1:0] w_sum;
    logic [COUNT_W-1:0] w_count_next;

    id_scan_ctrl_char_class u_char_class (
        .i_cls       (r_cls),
        .i_char      (bus.in_char),
        .o_next_cls  (w_next_cls),
        .o_match_end (w_match_end)
    );

    assign w_accept   = (r_state == ST_SCAN) && bus.in_valid;
    assign w_is_term  = (bus.in_char == TERM);
    assign w_len_next = r_len + 1'b1;
    assign w_hit_max  = (w_len_next == MAX_LEN_V);

    // Increment for the current accepted byte. A byte that fills the string
    // is followed by an implicit terminator, so a NUMBER result adds one more.
    always_comb begin
        w_inc = 2'd0;
        if (w_is_term) begin
            w_inc = (r_cls == CLS_NUMBER) ? 2'd1 : 2'd0;
        end else begin
            w_inc = {1'b0, w_match_end}
                  + {1'b0, (w_hit_max && (w_next_cls == CLS_NUMBER))};
        end
    end

    // Saturating add, computed two bits wider so the clamp covers the +2 case
    assign w_sum        = {2'b00, r_match_count} + {{COUNT_W{1'b0}}, w_inc};
    assign w_count_next = (w_sum > CNT_MAX) ? {COUNT_W{1'b1}} : w_sum[COUNT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cls         <= CLS_OTHER;
            r_match_count <= '0;
            r_len         <= '0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state       <= ST_SCAN;
                        r_cls         <= CLS_OTHER;
                        r_match_count <= '0;
                        r_len         <= '0;
                        r_overflow    <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_accept) begin
                        r_match_count <= w_count_next;
                        if (w_is_term) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_len <= w_len_next;
                            r_cls <= w_next_cls;
                            if (w_hit_max) begin
                                r_overflow <= 1'b1;
                                r_state    <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == ST_SCAN);
    assign bus.busy        = (r_state == ST_SCAN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.match_count = r_match_count;
    assign bus.len         = r_len;
    assign bus.overflow    = r_overflow;
    assign bus.dbg_state   = r_state;
    assign bus.dbg_cls     = r_cls;

endmodule
